// File: rtl/maindec_pkg.sv
// rtl/maindec_pkg.sv - shared types and constants for the multi-cycle LEGv8 main decoder
//
// Holds the FSM state encoding, the instruction class enum, the 11-bit
// opcode match patterns and the ALUOp codes. The EXC state only exists
// when MAINDEC_EXC_EN is defined.
package maindec_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_R_WB     = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_I_WB     = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_LD_WB    = 4'd8,
        ST_MEM_WR   = 4'd9,
`ifdef MAINDEC_EXC_EN
        ST_BRANCH   = 4'd10,
        ST_EXC      = 4'd11
`else
        ST_BRANCH   = 4'd10
`endif
    } state_t;

    typedef enum logic [2:0] {
        IC_INVALID = 3'd0,
        IC_R       = 3'd1,
        IC_I       = 3'd2,
        IC_LDUR    = 3'd3,
        IC_STUR    = 3'd4,
        IC_CBZ     = 3'd5,
        IC_CBNZ    = 3'd6
    } iclass_t;

    // '?' bits are don't-care in casez matching
    localparam logic [10:0] OPC_LDUR = 11'b111_1100_0010;
    localparam logic [10:0] OPC_STUR = 11'b111_1100_0000;
    localparam logic [10:0] OPC_CBZ  = 11'b101_1010_0???;
    localparam logic [10:0] OPC_CBNZ = 11'b101_1010_1???;
    localparam logic [10:0] OPC_ADD  = 11'b100_0101_1000;
    localparam logic [10:0] OPC_SUB  = 11'b110_0101_1000;
    localparam logic [10:0] OPC_AND  = 11'b100_0101_0000;
    localparam logic [10:0] OPC_ORR  = 11'b101_0101_0000;
    localparam logic [10:0] OPC_ADDI = 11'b100_1000_100?;
    localparam logic [10:0] OPC_SUBI = 11'b110_1000_100?;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASSB = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    // Classes whose second read register comes from the Rt field
    function automatic logic uses_rt(input iclass_t c);
        return (c == IC_STUR) || (c == IC_CBZ) || (c == IC_CBNZ);
    endfunction

endpackage

// File: rtl/op_classify.sv
// rtl/op_classify.sv - combinational opcode to instruction class map
//
// Ports:
//   op_i     [OP_W-1:0]  opcode field; only the top 11 bits are decoded
//   iclass_o iclass_t    instruction class, IC_INVALID when unrecognised
module op_classify
    import maindec_pkg::*;
#(
    parameter int OP_W = 11
) (
    input  logic [OP_W-1:0] op_i,
    output iclass_t         iclass_o
);

    logic [10:0] op11;
    assign op11 = op_i[OP_W-1 -: 11];

    always_comb begin
        iclass_o = IC_INVALID;
        casez (op11)
            OPC_LDUR: iclass_o = IC_LDUR;
            OPC_STUR: iclass_o = IC_STUR;
            OPC_CBZ:  iclass_o = IC_CBZ;
            OPC_CBNZ: iclass_o = IC_CBNZ;
            OPC_ADD,
            OPC_SUB,
            OPC_AND,
            OPC_ORR:  iclass_o = IC_R;
            OPC_ADDI,
            OPC_SUBI: iclass_o = IC_I;
            default:  iclass_o = IC_INVALID;
        endcase
    end

endmodule

// File: rtl/maindec_mc.sv
// rtl/maindec_mc.sv - multi-cycle LEGv8 main control FSM
//
// Moore FSM stepping each instruction through fetch, decode, execute,
// memory and write-back, with a bounded wait on MemReady.
// Build option MAINDEC_EXC_EN: invalid opcodes and memory timeouts enter a
// sticky EXC state (Exc=1 until reset); otherwise they fall back to FETCH.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   Op [OP_W-1:0]                opcode field from the instruction register
//   MemReady                     data memory finished the current access
//   Reg2Loc, ALUSrc, MemtoReg,
//   RegWrite, MemRead, MemWrite  datapath controls
//   Branch / BranchNZ            CBZ / CBNZ branch evaluate
//   ALUOp [1:0]                  ALU operation class
//   IRWrite, PCWrite             load IR, PC <- PC+4
//   Exc                          sticky fault flag
//   State [3:0]                  current state, debug
module maindec_mc
    import maindec_pkg::*;
#(
    parameter int OP_W        = 11,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] Op,
    input  logic            MemReady,
    output logic            Reg2Loc,
    output logic            ALUSrc,
    output logic            MemtoReg,
    output logic            RegWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            Branch,
    output logic            BranchNZ,
    output logic [1:0]      ALUOp,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic            Exc,
    output logic [3:0]      State
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

`ifdef MAINDEC_EXC_EN
    localparam state_t ST_FAULT = ST_EXC;
`else
    localparam state_t ST_FAULT = ST_FETCH;
`endif

    state_t        state_q;
    iclass_t       class_q;
    iclass_t       op_class;
    logic [CW-1:0] cnt_q;
    logic [CW:0]   cnt_inc;
    logic          mem_timeout;

    op_classify #(.OP_W(OP_W)) u_op_classify (
        .op_i     (Op),
        .iclass_o (op_class)
    );

    // One extra bit so the compare never wraps at MEM_TIMEOUT = 2^CW - 1
    assign cnt_inc     = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
    assign mem_timeout = (cnt_inc == (CW + 1)'(MEM_TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            class_q <= IC_INVALID;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_FETCH:  state_q <= ST_DECODE;
                ST_DECODE: begin
                    class_q <= op_class;
                    case (op_class)
                        IC_R:             state_q <= ST_EXEC_R;
                        IC_I:             state_q <= ST_EXEC_I;
                        IC_LDUR, IC_STUR: state_q <= ST_MEM_ADDR;
                        IC_CBZ, IC_CBNZ:  state_q <= ST_BRANCH;
                        default:          state_q <= ST_FAULT;
                    endcase
                end
                ST_EXEC_R: state_q <= ST_R_WB;
                ST_R_WB:   state_q <= ST_FETCH;
                ST_EXEC_I: state_q <= ST_I_WB;
                ST_I_WB:   state_q <= ST_FETCH;
                ST_MEM_ADDR: begin
                    cnt_q   <= '0;
                    state_q <= (class_q == IC_STUR) ? ST_MEM_WR : ST_MEM_RD;
                end
                ST_MEM_RD, ST_MEM_WR: begin
                    // MemReady takes priority over a timeout landing the same cycle
                    if (MemReady) begin
                        state_q <= (state_q == ST_MEM_RD) ? ST_LD_WB : ST_FETCH;
                    end else begin
                        cnt_q <= cnt_inc[CW-1:0];
                        if (mem_timeout) begin
                            state_q <= ST_FAULT;
                        end
                    end
                end
                ST_LD_WB:  state_q <= ST_FETCH;
                ST_BRANCH: state_q <= ST_FETCH;
`ifdef MAINDEC_EXC_EN
                ST_EXC:    state_q <= ST_EXC;
`endif
                default:   state_q <= ST_FETCH;
            endcase
        end
    end

    // Outputs decode the state register; reset forces everything low
    always_comb begin
        Reg2Loc  = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Branch   = 1'b0;
        BranchNZ = 1'b0;
        ALUOp    = ALU_ADD;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        Exc      = 1'b0;
        State    = 4'd0;
        if (!reset) begin
            State = state_q;
            case (state_q)
                ST_FETCH: begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
                // Register read starts here, before the class is latched
                ST_DECODE: Reg2Loc = uses_rt(op_class);
                ST_EXEC_R: ALUOp = ALU_RTYPE;
                ST_R_WB: begin
                    ALUOp    = ALU_RTYPE;
                    RegWrite = 1'b1;
                end
                ST_EXEC_I: begin
                    ALUSrc = 1'b1;
                    ALUOp  = ALU_ITYPE;
                end
                ST_I_WB: begin
                    ALUSrc   = 1'b1;
                    ALUOp    = ALU_ITYPE;
                    RegWrite = 1'b1;
                end
                ST_MEM_ADDR: ALUSrc = 1'b1;
                ST_MEM_RD: begin
                    MemRead = 1'b1;
                    ALUSrc  = 1'b1;
                end
                ST_LD_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                ST_MEM_WR: begin
                    MemWrite = 1'b1;
                    ALUSrc   = 1'b1;
                    Reg2Loc  = 1'b1;
                end
                ST_BRANCH: begin
                    ALUOp    = ALU_PASSB;
                    Reg2Loc  = 1'b1;
                    Branch   = (class_q == IC_CBZ);
                    BranchNZ = (class_q == IC_CBNZ);
                end
`ifdef MAINDEC_EXC_EN
                ST_EXC: Exc = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maindec_mc.sv
// tb/tb_maindec_mc.sv - directed self-checking bench for maindec_mc
module tb_maindec_mc;

    logic       clk = 1'b0;
    logic       reset;
    logic [10:0] Op;
    logic       MemReady;
    logic       Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite;
    logic       Branch, BranchNZ, IRWrite, PCWrite, Exc;
    logic [1:0] ALUOp;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    maindec_mc #(.OP_W(11), .MEM_TIMEOUT(15)) dut (
        .clk      (clk),
        .reset    (reset),
        .Op       (Op),
        .MemReady (MemReady),
        .Reg2Loc  (Reg2Loc),
        .ALUSrc   (ALUSrc),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Branch   (Branch),
        .BranchNZ (BranchNZ),
        .ALUOp    (ALUOp),
        .IRWrite  (IRWrite),
        .PCWrite  (PCWrite),
        .Exc      (Exc),
        .State    (State)
    );

    // {State, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, BranchNZ, ALUOp, IRWrite, PCWrite, Exc}
    logic [16:0] ctl;
    assign ctl = {State, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                  Branch, BranchNZ, ALUOp, IRWrite, PCWrite, Exc};

    localparam logic [16:0] E_ZERO    = 17'd0;
    localparam logic [16:0] E_FETCH   = {4'd0,  8'b0000_0000, 2'b00, 3'b110};
    localparam logic [16:0] E_DEC     = {4'd1,  8'b0000_0000, 2'b00, 3'b000};
    localparam logic [16:0] E_DEC_RT  = {4'd1,  8'b1000_0000, 2'b00, 3'b000};
    localparam logic [16:0] E_EXR     = {4'd2,  8'b0000_0000, 2'b10, 3'b000};
    localparam logic [16:0] E_RWB     = {4'd3,  8'b0001_0000, 2'b10, 3'b000};
    localparam logic [16:0] E_EXI     = {4'd4,  8'b0100_0000, 2'b11, 3'b000};
    localparam logic [16:0] E_IWB     = {4'd5,  8'b0101_0000, 2'b11, 3'b000};
    localparam logic [16:0] E_MADDR   = {4'd6,  8'b0100_0000, 2'b00, 3'b000};
    localparam logic [16:0] E_MRD     = {4'd7,  8'b0100_1000, 2'b00, 3'b000};
    localparam logic [16:0] E_LDWB    = {4'd8,  8'b0011_0000, 2'b00, 3'b000};
    localparam logic [16:0] E_MWR     = {4'd9,  8'b1100_0100, 2'b00, 3'b000};
    localparam logic [16:0] E_CBZ     = {4'd10, 8'b1000_0010, 2'b01, 3'b000};
    localparam logic [16:0] E_CBNZ    = {4'd10, 8'b1000_0001, 2'b01, 3'b000};
    localparam logic [16:0] E_EXC     = {4'd11, 8'b0000_0000, 2'b00, 3'b001};

    localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
    localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
    localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
    localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
    localparam logic [10:0] OP_CBZ  = 11'b101_1010_0010;
    localparam logic [10:0] OP_CBNZ = 11'b101_1010_1010;
    localparam logic [10:0] OP_ADDI = 11'b100_1000_1001;
    localparam logic [10:0] OP_SUBI = 11'b110_1000_1000;
    localparam logic [10:0] OP_BAD  = 11'b111_1111_1111;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge: inputs already set apply to this
    // cycle; outputs are compared at the falling edge.
    task automatic cyc(input string tag, input logic [16:0] e);
        @(negedge clk);
        check(tag, {15'd0, ctl}, {15'd0, e});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset_hold", E_ZERO);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        Op       = '0;
        MemReady = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset_state", E_ZERO);
        reset = 1'b0;

        // ADD: 4 cycles
        Op = OP_ADD;
        cyc("add_fetch", E_FETCH);
        cyc("add_dec", E_DEC);
        cyc("add_exec", E_EXR);
        cyc("add_wb", E_RWB);

        // LDUR, MemReady low 3 cycles, Op changes after DECODE are ignored
        Op = OP_LDUR;
        cyc("ld_fetch", E_FETCH);
        cyc("ld_dec", E_DEC);
        Op = OP_ADD;
        MemReady = 1'b0;
        cyc("ld_addr", E_MADDR);
        cyc("ld_rd0", E_MRD);
        cyc("ld_rd1", E_MRD);
        cyc("ld_rd2", E_MRD);
        MemReady = 1'b1;
        cyc("ld_rd3", E_MRD);
        cyc("ld_wb", E_LDWB);

        // CBZ / CBNZ: 3 cycles each
        Op = OP_CBZ;
        cyc("cbz_fetch", E_FETCH);
        cyc("cbz_dec", E_DEC_RT);
        cyc("cbz_br", E_CBZ);
        Op = OP_CBNZ;
        cyc("cbnz_fetch", E_FETCH);
        cyc("cbnz_dec", E_DEC_RT);
        cyc("cbnz_br", E_CBNZ);

        // ADDI / SUBI with the don't-care low bit both ways, ORR
        Op = OP_ADDI;
        cyc("addi_fetch", E_FETCH);
        cyc("addi_dec", E_DEC);
        cyc("addi_exec", E_EXI);
        cyc("addi_wb", E_IWB);
        Op = OP_SUBI;
        cyc("subi_fetch", E_FETCH);
        cyc("subi_dec", E_DEC);
        cyc("subi_exec", E_EXI);
        cyc("subi_wb", E_IWB);
        Op = OP_ORR;
        cyc("orr_fetch", E_FETCH);
        cyc("orr_dec", E_DEC);
        cyc("orr_exec", E_EXR);
        cyc("orr_wb", E_RWB);

        // STUR, memory ready at once: 4 cycles
        Op = OP_STUR;
        cyc("st_fetch", E_FETCH);
        cyc("st_dec", E_DEC_RT);
        cyc("st_addr", E_MADDR);
        cyc("st_wr", E_MWR);

        // LDUR: ready rises on the 15th wait cycle, same cycle as the timeout
        Op = OP_LDUR;
        MemReady = 1'b0;
        cyc("ldb_fetch", E_FETCH);
        cyc("ldb_dec", E_DEC);
        cyc("ldb_addr", E_MADDR);
        for (int i = 0; i < 14; i++) cyc("ldb_rd", E_MRD);
        MemReady = 1'b1;
        cyc("ldb_rd_last", E_MRD);
        cyc("ldb_wb", E_LDWB);

        // Reset in the middle of MEM_RD
        Op = OP_LDUR;
        MemReady = 1'b0;
        cyc("ldr_fetch", E_FETCH);
        cyc("ldr_dec", E_DEC);
        cyc("ldr_addr", E_MADDR);
        cyc("ldr_rd", E_MRD);
        reset = 1'b1;
        cyc("ldr_reset", E_ZERO);
        reset = 1'b0;
        cyc("ldr_refetch", E_FETCH);
        cyc("ldr_dec2", E_DEC);
        cyc("ldr_addr2", E_MADDR);
        for (int i = 0; i < 10; i++) cyc("ldr_rd2", E_MRD);
        MemReady = 1'b1;
        cyc("ldr_rd2_last", E_MRD);
        cyc("ldr_wb2", E_LDWB);

        // STUR with MemReady held low: 15 MEM_WR cycles then timeout
        Op = OP_STUR;
        MemReady = 1'b0;
        cyc("sto_fetch", E_FETCH);
        cyc("sto_dec", E_DEC_RT);
        cyc("sto_addr", E_MADDR);
        for (int i = 0; i < 15; i++) cyc("sto_wr", E_MWR);
`ifdef MAINDEC_EXC_EN
        cyc("sto_exc0", E_EXC);
        MemReady = 1'b1;
        cyc("sto_exc1", E_EXC);
        cyc("sto_exc2", E_EXC);
        do_reset();
        MemReady = 1'b1;
`else
        Op = OP_LDUR;
        cyc("sto_refetch", E_FETCH);
        // timed-out load returns to FETCH with no write-back
        cyc("ldo_dec", E_DEC);
        cyc("ldo_addr", E_MADDR);
        for (int i = 0; i < 15; i++) cyc("ldo_rd", E_MRD);
        MemReady = 1'b1;
`endif

        // Invalid opcode
        Op = OP_BAD;
        cyc("bad_fetch", E_FETCH);
        cyc("bad_dec", E_DEC);
`ifdef MAINDEC_EXC_EN
        cyc("bad_exc0", E_EXC);
        cyc("bad_exc1", E_EXC);
        do_reset();
`endif
        Op = OP_ADD;
        cyc("post_fetch", E_FETCH);
        cyc("post_dec", E_DEC);
        cyc("post_exec", E_EXR);
        cyc("post_wb", E_RWB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
